ycbcr_frame_arbiter: RTL
========================

Name: ycbcr_frame_arbiter

Overview:
Shares one RGB888-to-YCbCr444 converter between two camera pixel streams by granting whole frames. Arbitration happens only at frame boundaries, with round-robin on ties. The block sits between two capture front-ends and the converter input. It outputs a source-ID tag delayed to line up with the converter output, and it counts frames that were dropped.

Parameters:
CONV_LAT, 3, converter pipeline latency in clk cycles; sets the tag delay.
TIMEOUT, 24'd1_000_000, maximum cycles a granted frame may keep vsync high before it is aborted.
CNT_W, 8, width of the saturating drop counters.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
src_en  in  2  per-source enable; bit i=0 means source i is never granted
s0_vsync  in  1  source 0 frame valid, high for the whole frame
s0_href  in  1  source 0 line valid
s0_clken  in  1  source 0 pixel strobe
s0_rgb  in  24  source 0 pixel {R,G,B}
s1_vsync, s1_href, s1_clken, s1_rgb  in  1/1/1/24  source 1, same meaning as source 0
m_vsync  out  1  to converter
m_href  out  1  to converter
m_clken  out  1  to converter
m_rgb  out  24  to converter {R,G,B}
tag_id  out  1  source of the pixel currently leaving the converter
tag_valid  out  1  tag_id is meaningful
drop_cnt0  out  CNT_W  frames of source 0 not granted (saturating)
drop_cnt1  out  CNT_W  frames of source 1 not granted (saturating)
timeout_err  out  1  sticky; set when a granted frame is aborted by timeout

Behaviour:
- Reset: every output 0, state IDLE, last_grant=1 (so source 0 wins the first tie), edge-detect registers 0, timeout counter 0.
- Frame edges: each vsync is registered once. rise_i = vsync_i & ~vsync_d_i; fall_i = ~vsync_i & vsync_d_i. Both are evaluated on the raw input edge cycle.
- State machine: IDLE, GRANT0, GRANT1.
  - IDLE:
    - If exactly one enabled source has rise_i, go to GRANTi.
    - If both rise in the same cycle, grant the source != last_grant; the other source's frame counts as dropped.
    - A source whose vsync is already high on entry to IDLE is not granted mid-frame. It waits for its next rise.
  - GRANTi:
    - On fall_i, set last_grant=i and return to IDLE.
    - Any rise_j of the other source (enabled) increments drop_cntj, saturating at all-ones.
    - A rise of a disabled source is not counted.
  - Timeout:
    - The counter clears on grant and increments each GRANT cycle.
    - When it reaches TIMEOUT-1, return to IDLE, set timeout_err, set last_grant=i, and zero the m_* outputs from the next cycle.
    - The aborted source is not re-granted until it shows a fresh rise.
  - Simultaneous fall_i and rise_j in a GRANT state: fall wins and the state goes to IDLE. The rise_j frame is dropped and counted, because grants start only from IDLE.
  - src_en_i deasserted during GRANTi: the frame completes normally, and no new grant is made to i.
- Datapath:
  - m_* = registered mux of the granted source's vsync/href/clken/rgb. This is 1 cycle latency from the source pins.
  - The mux select uses the next-state grant, so the rising-edge pixel cycle itself is forwarded. m_vsync therefore rises exactly 1 cycle after the granted s_vsync rises.
  - The falling-edge cycle forwards 0 (the source's own vsync value).
  - While IDLE, m_* = 0.
- Tag:
  - {valid, id} = {granted, grant_id} on the m_* cycle, delayed by a further CONV_LAT-stage shift register.
  - So tag_valid/tag_id align with the converter post_* outputs.
  - On reset the shift register clears.
- Reset mid-frame: everything clears immediately and asynchronously. After release, any frame already in progress is ignored until its next rise.
- drop_cnt and timeout_err clear only on reset.

Test Plan:
1. Source 0 only: 4-line × 8-pixel frame, pixel value 0x102030 → m_* equals source 0 delayed exactly 1 cycle; tag_valid=1 and tag_id=0 appear CONV_LAT cycles after m_vsync rises; drop_cnt0=drop_cnt1=0.
2. Both vsync rise in the same cycle after reset → GRANT0; drop_cnt1=1. Repeat the simultaneous rise after the frame ends → GRANT1; drop_cnt0=1 (alternation).
3. Source 1 rises 10 cycles into a source 0 frame → source 1 pixels are never on m_*; drop_cnt1 increments by 1. Source 1's frame is still high when source 0 ends → no grant until source 1's next rise.
4. TIMEOUT=16; source 0 holds vsync high for 40 cycles → m_vsync drops after 16 grant cycles; timeout_err=1 and stays 1; source 0 is granted again only on its next rise.
5. src_en=2'b10; both sources toggle frames → only source 1 is granted; drop_cnt0 stays 0.
6. 300 dropped source 1 frames with CNT_W=8 → drop_cnt1 saturates at 255. Assert rst_n mid-frame → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/ycbcr_frame_arbiter.sv
// Frame-granular arbiter sharing one RGB->YCbCr converter between two camera streams.
// Grants whole frames at vsync edges, tags converter output with its source, counts dropped frames.
module ycbcr_frame_arbiter #(
    parameter int unsigned CONV_LAT = 3,
    parameter logic [23:0] TIMEOUT  = 24'd1_000_000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       src_en,
    input  logic             s0_vsync,
    input  logic             s0_href,
    input  logic             s0_clken,
    input  logic [23:0]      s0_rgb,
    input  logic             s1_vsync,
    input  logic             s1_href,
    input  logic             s1_clken,
    input  logic [23:0]      s1_rgb,
    output logic             m_vsync,
    output logic             m_href,
    output logic             m_clken,
    output logic [23:0]      m_rgb,
    output logic             tag_id,
    output logic             tag_valid,
    output logic [CNT_W-1:0] drop_cnt0,
    output logic [CNT_W-1:0] drop_cnt1,
    output logic             timeout_err
);

    localparam int unsigned TCNT_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                last_grant_nxt;
    logic [1:0]          vs;
    logic [1:0]          vsync_d;
    logic [1:0]          seen_low;
    logic [1:0]          rise;
    logic [1:0]          fall;
    logic [1:0]          cand;
    logic [1:0]          drop_inc;
    logic [TCNT_W-1:0]   tcnt;
    logic                tcnt_clr;
    logic                abort;
    logic                sel_valid;
    logic                sel_id;
    logic [CONV_LAT:0]   tv_sr;
    logic [CONV_LAT:0]   ti_sr;

    // A rise only counts once vsync has been sampled low, so frames already running at reset release are skipped.
    assign vs        = {s1_vsync, s0_vsync};
    assign rise      = vs & ~vsync_d & seen_low;
    assign fall      = ~vs & vsync_d;
    assign cand      = rise & src_en;
    assign sel_valid = (state_nxt != IDLE);
    assign sel_id    = (state_nxt == GRANT1);

    // Next-state, drop and abort decisions.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        drop_inc       = 2'b00;
        tcnt_clr       = 1'b0;
        abort          = 1'b0;
        case (state)
            IDLE: begin
                tcnt_clr = 1'b1;
                if (cand == 2'b11) begin
                    state_nxt = last_grant ? GRANT0 : GRANT1;
                    drop_inc  = last_grant ? 2'b10 : 2'b01;
                end else if (cand[0]) begin
                    state_nxt = GRANT0;
                end else if (cand[1]) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                drop_inc[1] = rise[1] & src_en[1];
                if (fall[0]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b0;
                end else if (tcnt == TIMEOUT - 24'd1) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b0;
                    abort          = 1'b1;
                end
            end
            GRANT1: begin
                drop_inc[0] = rise[0] & src_en[0];
                if (fall[1]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b1;
                end else if (tcnt == TIMEOUT - 24'd1) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = 1'b1;
                    abort          = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            vsync_d     <= 2'b00;
            seen_low    <= 2'b00;
            tcnt        <= '0;
            m_vsync     <= 1'b0;
            m_href      <= 1'b0;
            m_clken     <= 1'b0;
            m_rgb       <= '0;
            tv_sr       <= '0;
            ti_sr       <= '0;
            drop_cnt0   <= '0;
            drop_cnt1   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            vsync_d    <= vs;
            seen_low   <= seen_low | ~vs;
            tcnt       <= tcnt_clr ? '0 : tcnt + TCNT_W'(1);

            // Mux follows the next-state grant so the rising-edge cycle is forwarded.
            if (!sel_valid) begin
                m_vsync <= 1'b0;
                m_href  <= 1'b0;
                m_clken <= 1'b0;
                m_rgb   <= '0;
            end else if (sel_id) begin
                m_vsync <= s1_vsync;
                m_href  <= s1_href;
                m_clken <= s1_clken;
                m_rgb   <= s1_rgb;
            end else begin
                m_vsync <= s0_vsync;
                m_href  <= s0_href;
                m_clken <= s0_clken;
                m_rgb   <= s0_rgb;
            end

            // Stage 0 lines up with m_*, the last stage with the converter output.
            tv_sr <= {tv_sr[CONV_LAT-1:0], sel_valid};
            ti_sr <= {ti_sr[CONV_LAT-1:0], sel_id};

            if (drop_inc[0] && (drop_cnt0 != '1)) begin
                drop_cnt0 <= drop_cnt0 + CNT_W'(1);
            end
            if (drop_inc[1] && (drop_cnt1 != '1)) begin
                drop_cnt1 <= drop_cnt1 + CNT_W'(1);
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign tag_valid = tv_sr[CONV_LAT];
    assign tag_id    = ti_sr[CONV_LAT];

endmodule
